// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the cascaded modulo counter (mod_counter_chain).
package mod_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int MAX_VEC_W = 256;

    function automatic int digit_max(input int modulus);
        return modulus - 1;
    endfunction

    // Extract field k (w bits wide) from a packed vector; w is at most 32.
    function automatic logic [31:0] field_of(input logic [MAX_VEC_W-1:0] vec,
                                             input int k,
                                             input int w);
        logic [MAX_VEC_W-1:0] sh;
        logic [31:0]          mask;
        sh   = vec >> (k * w);
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return 32'(sh) & mask;
    endfunction

endpackage

// File: rtl/mod_counter_digit.sv
// One modulo-MOD digit: load with clamp, up/down step with wrap, registered carry pulse.
module mod_counter_digit
    import mod_counter_pkg::*;
#(
    parameter int MOD   = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             step,
    input  logic             up_dn,
    output logic [CNT_W-1:0] value,
    output logic             wrap_next,
    output logic             carry
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(digit_max(MOD));
    localparam logic [CNT_W:0]   MOD_W = (CNT_W + 1)'(MOD);

    logic [CNT_W-1:0] r_val;
    logic             r_carry;
    dir_e             w_dir;
    logic             w_load_bad;

    assign w_dir      = dir_e'(up_dn);
    assign w_load_bad = ({1'b0, load_val} >= MOD_W);

    // True when a step taken now would wrap this digit in the current direction.
    assign wrap_next = (w_dir == DIR_UP) ? (r_val == MAX_V) : (r_val == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_val   <= '0;
            r_carry <= 1'b0;
        end else if (load) begin
            r_val   <= w_load_bad ? '0 : load_val;
            r_carry <= 1'b0;
        end else begin
            r_carry <= step & wrap_next;
            if (step) begin
                if (w_dir == DIR_UP)
                    r_val <= wrap_next ? '0 : r_val + CNT_W'(1);
                else
                    r_val <= wrap_next ? MAX_V : r_val - CNT_W'(1);
            end
        end
    end

    assign value = r_val;
    assign carry = r_carry;

endmodule

// File: rtl/mod_counter_chain.sv
// Cascade of DIGITS modulo-MOD counters with up/down, load, enable and per-digit carry.
// Optional sticky overflow flag (ovf/ovf_clr) built when MOD_COUNTER_STICKY_OVF_EN is defined.
module mod_counter_chain
    import mod_counter_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int MOD    = 10,
    parameter int CNT_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [DIGITS*CNT_W-1:0] load_val,
`ifdef MOD_COUNTER_STICKY_OVF_EN
    input  logic                    ovf_clr,
    output logic                    ovf,
`endif
    output logic [DIGITS*CNT_W-1:0] cnt,
    output logic [DIGITS-1:0]       digit_carry,
    output logic                    cout,
    output logic                    tc
);

    logic [DIGITS-1:0] w_step;
    logic [DIGITS-1:0] w_wrap_next;
    logic [DIGITS-1:0] w_carry;

    // Ripple enable: digit k steps only when every lower digit is about to wrap.
    assign w_step[0] = en;

    genvar k;
    generate
        for (k = 1; k < DIGITS; k++) begin : g_ripple
            assign w_step[k] = w_step[k-1] & w_wrap_next[k-1];
        end

        for (k = 0; k < DIGITS; k++) begin : g_digit
            logic [CNT_W-1:0] w_load_digit;
            assign w_load_digit = CNT_W'(field_of(MAX_VEC_W'(load_val), k, CNT_W));

            mod_counter_digit #(
                .MOD   (MOD),
                .CNT_W (CNT_W)
            ) u_digit (
                .clk       (clk),
                .rst       (rst),
                .load      (load),
                .load_val  (w_load_digit),
                .step      (w_step[k]),
                .up_dn     (up_dn),
                .value     (cnt[k*CNT_W +: CNT_W]),
                .wrap_next (w_wrap_next[k]),
                .carry     (w_carry[k])
            );
        end
    endgenerate

    assign digit_carry = w_carry;
    assign cout        = w_carry[DIGITS-1];
    assign tc          = &w_wrap_next;

`ifdef MOD_COUNTER_STICKY_OVF_EN
    logic w_cout_next;
    logic r_ovf;

    // Set on the same edge that raises cout, so a coincident clear loses.
    assign w_cout_next = w_step[DIGITS-1] & w_wrap_next[DIGITS-1] & ~load;

    always_ff @(posedge clk) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (w_cout_next)
            r_ovf <= 1'b1;
        else if (ovf_clr)
            r_ovf <= 1'b0;
    end

    assign ovf = r_ovf;
`endif

endmodule
